// File: rtl/serial_nibble_adder_if.sv
// Operand/result bus between an operand source and serial_nibble_adder.
//
// Handshake: the source raises start with a_in/b_in/carry_in valid; the adder
// samples them on the first rising edge at which it is idle, then shows busy for
// NUM_NIBBLES cycles, then pulses done for one cycle. sum_out/overflow are valid
// from the done cycle onward and hold until the next done. The source may drop
// or change its inputs any time after the accepting edge.
interface serial_nibble_adder_if #(
  parameter int NUM_NIBBLES = 4
);
  logic                     start;
  logic [4*NUM_NIBBLES-1:0] a_in;
  logic [4*NUM_NIBBLES-1:0] b_in;
  logic                     carry_in;
  logic                     busy;
  logic                     done;
  logic [4*NUM_NIBBLES-1:0] sum_out;
  logic                     overflow;

  modport master (
    output start, a_in, b_in, carry_in,
    input  busy, done, sum_out, overflow
  );

  modport slave (
    input  start, a_in, b_in, carry_in,
    output busy, done, sum_out, overflow
  );
endinterface

// File: rtl/serial_nibble_adder.sv
// Multi-precision unsigned adder: one 4-bit add per clock, carry registered
// between nibbles, result and carry-out published when the last nibble lands.
module serial_nibble_adder #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  serial_nibble_adder_if.slave  bus,
  output logic [1:0]            state_dbg
);

  localparam int W  = 4 * NUM_NIBBLES;
  localparam int CW = $clog2(NUM_NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [W-1:0]  partial;
  logic [W-1:0]  sum_r;
  logic          ovf_r;
  logic          busy_r;
  logic          done_r;

  logic [CW+1:0] nib_idx;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    nib_sum;
  logic [W-1:0]  partial_next;

  // Select the current nibble of each latched operand and add it with the carry.
  assign nib_idx = {cnt, 2'b00};
  assign a_nib   = a_reg[nib_idx +: 4];
  assign b_nib   = b_reg[nib_idx +: 4];
  assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_reg};

  // Partial sum with the nibble being computed this cycle merged in, so the
  // final nibble is included when the result is published.
  always_comb begin
    partial_next = partial;
    partial_next[nib_idx +: 4] = nib_sum[3:0];
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      partial   <= '0;
      sum_r     <= '0;
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            carry_reg <= bus.carry_in;
            cnt       <= '0;
            partial   <= '0;
            busy_r    <= 1'b1;
            state     <= ADD;
          end
        end
        ADD: begin
          partial   <= partial_next;
          carry_reg <= nib_sum[4];
          if (cnt == LAST) begin
            sum_r  <= partial_next;
            ovf_r  <= nib_sum[4];
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          done_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.sum_out  = sum_r;
  assign bus.overflow = ovf_r;
  assign state_dbg    = state;

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Self-checking bench for serial_nibble_adder at NUM_NIBBLES = 4.
module tb_serial_nibble_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic       clk;
  logic       n_rst;
  logic [1:0] state_dbg;

  serial_nibble_adder_if #(.NUM_NIBBLES(N)) bus ();

  serial_nibble_adder #(.NUM_NIBBLES(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];
  logic [W:0] last_result;
  int n_checks;
  int n_fail;
  int n_started;
  int n_done;
  bit b2b_phase;
  int unsigned last_done_cyc;
  bit have_last_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  // Output monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (bus.busy || bus.done)
      check("busy_done_excl", {31'd0, bus.busy & bus.done}, 32'd0);
    if (bus.done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("result", {15'd0, bus.overflow, bus.sum_out}, {15'd0, e});
        last_result = e;
      end
      if (b2b_phase && have_last_done)
        check("start_spacing", cyc - last_done_cyc, 32'd6);
      last_done_cyc  = cyc;
      have_last_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one addition from idle and check busy/done timing cycle by cycle.
  // With disturb set, start is re-pulsed and the operands scrambled mid-ADD.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input bit disturb);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.carry_in = cin; bus.start = 1'b1;
    exp_q.push_back(ref_add(a, b, cin));
    n_started++;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb && k == 2) begin
        bus.start = 1'b1;
        bus.a_in  = W'($urandom_range(0, 65535));
        bus.b_in  = W'($urandom_range(0, 65535));
        bus.carry_in = ~cin;
      end
      check("busy_phase", {30'd0, bus.busy, bus.done}, 32'b10);
      check("sum_hold", {15'd0, bus.overflow, bus.sum_out}, {15'd0, last_result});
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("done_phase", {30'd0, bus.busy, bus.done}, 32'b01);
    @(negedge clk);
    check("after_done", {30'd0, bus.busy, bus.done}, 32'b00);
    check("state_idle", {30'd0, state_dbg}, 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cyc = 0; n_checks = 0; n_fail = 0; n_started = 0; n_done = 0;
    b2b_phase = 1'b0; have_last_done = 1'b0; last_result = '0;
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.carry_in = 1'b0;

    // Reset then idle.
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset_idle", {13'd0, bus.busy, bus.done, bus.overflow, bus.sum_out}, 32'd0);
    end

    // Basic add and full-carry ripple cases.
    run_one(16'h1234, 16'h4321, 1'b1, 1'b0);
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    idle_cycles(3);
    check("hold_idle", {15'd0, bus.overflow, bus.sum_out}, {15'd0, 17'h1FFFF});

    // Start re-pulsed and operands changed during ADD.
    run_one(16'h1111, 16'h2222, 1'b0, 1'b1);
    idle_cycles(3);
    check("single_done", n_done, n_started);

    // Reset after two ADD cycles discards the addition.
    @(negedge clk);
    bus.a_in = 16'h1234; bus.b_in = 16'h5678; bus.carry_in = 1'b1; bus.start = 1'b1;
    exp_q.push_back(ref_add(16'h1234, 16'h5678, 1'b1));
    n_started++;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("mid_reset_out", {13'd0, bus.busy, bus.done, bus.overflow, bus.sum_out}, 32'd0);
    check("mid_reset_state", {30'd0, state_dbg}, 32'd0);
    exp_q.delete();
    n_started--;
    last_result = '0;
    @(negedge clk);
    n_rst = 1'b1;
    idle_cycles(8);
    check("no_done_after_reset", n_done, n_started);
    run_one(16'h00FF, 16'h0001, 1'b0, 1'b0);

    // Randomized back-to-back with start held high.
    b2b_phase = 1'b1;
    have_last_done = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      c = 1'($urandom_range(0, 1));
      bus.a_in = a; bus.b_in = b; bus.carry_in = c; bus.start = 1'b1;
      exp_q.push_back(ref_add(a, b, c));
      n_started++;
      repeat (6) @(negedge clk);
    end
    bus.start = 1'b0;
    idle_cycles(10);
    b2b_phase = 1'b0;

    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", n_done, n_started);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_nibble_adder.md
# serial_nibble_adder

Multi-precision unsigned adder that sums two NUM_NIBBLES×4-bit operands four bits per clock. Each cycle performs one 4-bit add with carry-in and captures the 4-bit sum plus overflow, so its datapath is the same nibble add as adder_4bit. The ripple carry is registered between cycles. It sits between an operand source using a start/done handshake and the downstream consumer of the wide sum, and trades latency for a single 4-bit adder instead of a wide combinational chain.

## Interface
- NUM_NIBBLES, default 4: operand width in nibbles (16-bit operands at default); legal range 2–16.
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  reset; asynchronous, active-low
- start  input  1  request to begin an addition; sampled only in IDLE
- a_in  input  4*NUM_NIBBLES  operand A, unsigned
- b_in  input  4*NUM_NIBBLES  operand B, unsigned
- carry_in  input  1  carry into nibble 0
- busy  output  1  high while state is ADD
- done  output  1  single-cycle pulse, high while state is DONE
- sum_out  output  4*NUM_NIBBLES  registered result of the last completed addition
- overflow  output  1  registered carry out of the top nibble of the last completed addition

## Operation
- States:
  - IDLE → ADD on start=1.
  - ADD → ADD while nibble counter < NUM_NIBBLES-1.
  - ADD → DONE when counter = NUM_NIBBLES-1.
  - DONE → IDLE unconditionally.
- Accepting start in IDLE:
  - Latch a_in, b_in and carry_in into internal operand registers.
  - Clear the nibble counter and the partial-sum register.
  - Load the carry register with carry_in.
- Each ADD cycle with counter = i:
  - Compute {c, s} = A[4i+3:4i] + B[4i+3:4i] + carry_reg, 5-bit unsigned.
  - Write s into partial[4i+3:4i] and c into carry_reg, then increment the counter.
- On the ADD→DONE edge:
  - Copy the completed partial sum (including the final nibble) to sum_out.
  - Copy the final carry to overflow.
- sum_out and overflow change only on the ADD→DONE edge. They hold between additions.
- start while in ADD or DONE is ignored, and input changes during ADD have no effect because operands are latched.
- Result is exact modulo 2^(4*NUM_NIBBLES), and overflow = 1 iff A + B + carry_in ≥ 2^(4*NUM_NIBBLES).
- Reset (n_rst=0, any time including mid-ADD) takes effect asynchronously:
  - State → IDLE; counter, carry and partial registers cleared.
  - busy=0, done=0, sum_out=0, overflow=0.
  - The addition in flight is discarded with no done pulse.

## Timing
- Reset values: busy=0, done=0, sum_out=0, overflow=0, state IDLE.
- Start accepted at rising edge E0:
  - busy goes high after E0 and stays high for NUM_NIBBLES cycles.
  - Nibble i is processed on edge E(i+1).
  - sum_out and overflow become valid, and done goes high, after edge E(NUM_NIBBLES).
  - done drops after E(NUM_NIBBLES+1), when the state returns to IDLE.
- busy and done are never high together; exactly one done pulse is produced per accepted start.
- Minimum start-to-start spacing is NUM_NIBBLES+2 cycles. With start held high continuously, a new addition is accepted at the first edge in IDLE.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset then idle: n_rst low 2 cycles, start=0 → busy=0, done=0, sum_out=0x0000, overflow=0 for 10 cycles.
- Basic add (NUM_NIBBLES=4): start with A=0x1234, B=0x4321, carry_in=1 → busy high 4 cycles, done high on the 5th cycle after the start edge, sum_out=0x5556, overflow=0.
- Full carry ripple: A=0xFFFF, B=0x0001, carry_in=0 → sum_out=0x0000, overflow=1. Second case A=0xFFFF, B=0xFFFF, carry_in=1 → sum_out=0xFFFF, overflow=1.
- Ignored start and operand changes:
  - Pulse start again and change a_in/b_in during ADD → result matches the originally latched operands, only one done pulse.
  - Previous sum_out holds until the new DONE edge.
- Reset mid-operation: assert n_rst after 2 ADD cycles → immediate busy=0, sum_out=0, overflow=0, no done pulse. A following start with 0x00FF+0x0001 gives 0x0100, overflow=0.
- Randomized back-to-back: 1000 random A, B, carry_in with start held high → each done matches a reference 17-bit sum, and starts are spaced exactly 6 cycles apart.
